// File: rtl/fsm_send_harq_if.sv
// Output stream from fsm_send_harq to the HARQ sink: saturated LLR word with a
// valid/ready handshake. Signal names follow the DUT's view of the stream.
interface fsm_send_harq_if #(
    parameter int NUM_LLR   = 16,
    parameter int LLR_OUT_W = 6
);
    logic [NUM_LLR*LLR_OUT_W-1:0] o_HARQ_Data;
    logic                         o_HARQ_Data_Valid;
    logic                         i_HARQ_Ready;

    modport master (
        output o_HARQ_Data,
        output o_HARQ_Data_Valid,
        input  i_HARQ_Ready
    );

    modport slave (
        input  o_HARQ_Data,
        input  o_HARQ_Data_Valid,
        output i_HARQ_Ready
    );
endinterface

// File: rtl/fsm_send_harq.sv
// Reads one combine buffer (ping or pong) from address 0 to the Ncb-derived last
// word, saturates every LLR to the output width and streams it out through a 2-entry FIFO.
module fsm_send_harq #(
    parameter int NUM_LLR    = 16,
    parameter int LLR_IN_W   = 10,
    parameter int LLR_OUT_W  = 6,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rst,
    input  logic                          i_SENDHARQ_Data_request,
    input  logic                          i_SENDHARQ_Data_PingPong_Indicator,
    input  logic [15:0]                   i_SENDHARQ_Data_ncb,
    output logic [ADDR_WIDTH-1:0]         o_SENDHARQ_Data_Address,
    output logic                          o_SENDHARQ_Buffer_Select,
    input  logic [NUM_LLR*LLR_IN_W-1:0]   i_COMB_Data_Read,
    fsm_send_harq_if.master               harq,
    output logic                          o_SENDHARQ_Data_Comp,
    output logic                          o_busy
);

    localparam int OUT_W = NUM_LLR * LLR_OUT_W;
    localparam logic [31:0] ADDR_MAX = 32'((64'd1 << ADDR_WIDTH) - 64'd1);
    localparam logic signed [LLR_IN_W-1:0] SAT_MAX = LLR_IN_W'((1 << (LLR_OUT_W - 1)) - 1);
    localparam logic signed [LLR_IN_W-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        READ     = 4'b0010,
        DRAIN    = 4'b0100,
        COMPLETE = 4'b1000
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic [ADDR_WIDTH-1:0]   last_calc;
    logic                    sel_q;
    logic                    inflight;
    logic                    comp_q;
    logic [OUT_W-1:0]        fifo_mem [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_count;
    logic [2:0]              occupancy;
    logic                    pop;
    logic                    issue;
    logic [11:0]             ncb_word;
    logic [OUT_W-1:0]        sat_word;
    logic signed [LLR_IN_W-1:0] llr;
    logic                    unused_ncb_bits;

    assign ncb_word        = i_SENDHARQ_Data_ncb[15:4];
    assign unused_ncb_bits = ^i_SENDHARQ_Data_ncb[3:0];
    assign last_calc       = (32'(ncb_word) > ADDR_MAX) ? '1 : ADDR_WIDTH'(ncb_word);

    // Occupancy counts the word already on its way back from the buffer, so a
    // new read is only issued when the FIFO is guaranteed room for it.
    assign pop       = (fifo_count != 2'd0) && harq.i_HARQ_Ready;
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = (state == READ) && (occupancy < 3'd2);

    always_comb begin
        sat_word = '0;
        llr      = '0;
        for (int k = 0; k < NUM_LLR; k++) begin
            llr = i_COMB_Data_Read[k*LLR_IN_W +: LLR_IN_W];
            if (llr > SAT_MAX)
                sat_word[k*LLR_OUT_W +: LLR_OUT_W] = SAT_MAX[LLR_OUT_W-1:0];
            else if (llr < SAT_MIN)
                sat_word[k*LLR_OUT_W +: LLR_OUT_W] = SAT_MIN[LLR_OUT_W-1:0];
            else
                sat_word[k*LLR_OUT_W +: LLR_OUT_W] = llr[LLR_OUT_W-1:0];
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            sel_q       <= 1'b0;
            inflight    <= 1'b0;
            comp_q      <= 1'b0;
            fifo_count  <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            inflight   <= issue;
            comp_q     <= 1'b0;
            fifo_count <= occupancy[1:0];
            if (inflight) begin
                fifo_mem[wr_ptr] <= sat_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;

            case (state)
                IDLE: begin
                    if (i_SENDHARQ_Data_request) begin
                        sel_q  <= i_SENDHARQ_Data_PingPong_Indicator;
                        last_q <= last_calc;
                        addr_q <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr_q == last_q)
                            state <= DRAIN;
                        else
                            addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!inflight && fifo_count == 2'd1 && pop) begin
                        state  <= COMPLETE;
                        comp_q <= 1'b1;
                    end
                end
                COMPLETE: begin
                    state  <= IDLE;
                    addr_q <= '0;
                    last_q <= '0;
                    sel_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_SENDHARQ_Data_Address  = addr_q;
    assign o_SENDHARQ_Buffer_Select = sel_q;
    assign harq.o_HARQ_Data_Valid   = (fifo_count != 2'd0);
    assign harq.o_HARQ_Data         = (fifo_count != 2'd0) ? fifo_mem[rd_ptr] : '0;
    assign o_SENDHARQ_Data_Comp     = comp_q;
    assign o_busy                   = (state != IDLE);

endmodule

// File: tb/tb_fsm_send_harq.sv
// Scoreboard bench for fsm_send_harq: a behavioural buffer model feeds the DUT and
// every delivered word is compared against independently saturated expectations.
module tb_fsm_send_harq;

    logic          clk;
    logic          rst;
    logic          request;
    logic          indicator;
    logic [15:0]   ncb_in;
    logic [10:0]   address;
    logic          buf_sel;
    logic [159:0]  comb_data;
    logic          comp;
    logic          busy;
    logic          ready;
    logic          ready_mode;

    int            check_count;
    int            error_count;
    int            cycle_count;
    int            comp_count;
    int            words_in_txn;
    int            words_total;
    int            last_xfer_cycle;
    logic          stall_pending;
    logic [95:0]   stall_data;
    logic [95:0]   exp_q [$];

    fsm_send_harq_if #(.NUM_LLR(16), .LLR_OUT_W(6)) harq_bus ();

    assign harq_bus.i_HARQ_Ready = ready;

    fsm_send_harq #(
        .NUM_LLR(16), .LLR_IN_W(10), .LLR_OUT_W(6), .ADDR_WIDTH(11)
    ) dut (
        .i_core_clk                         (clk),
        .i_rx_rst                           (rst),
        .i_SENDHARQ_Data_request            (request),
        .i_SENDHARQ_Data_PingPong_Indicator (indicator),
        .i_SENDHARQ_Data_ncb                (ncb_in),
        .o_SENDHARQ_Data_Address            (address),
        .o_SENDHARQ_Buffer_Select           (buf_sel),
        .i_COMB_Data_Read                   (comb_data),
        .harq                               (harq_bus),
        .o_SENDHARQ_Data_Comp               (comp),
        .o_busy                             (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_count++;

    function automatic int llr_val(logic sel, int addr, int k);
        if (!sel && addr == 0) begin
            case (k)
                0: return 200;   1: return -200;  2: return 31;   3: return -31;
                4: return 0;     5: return -1;    6: return 32;   7: return -32;
                8: return 511;   9: return -512; 10: return 15;  11: return -16;
                12: return 30;  13: return -30;  14: return 33;  default: return -33;
            endcase
        end
        return ((addr * 37 + k * 101 + (sel ? 911 : 0) + 13) % 1024) - 512;
    endfunction

    function automatic int sat_ref(int v);
        if (v > 31) return 31;
        if (v < -31) return -31;
        return v;
    endfunction

    function automatic logic [159:0] build_word(logic sel, int addr);
        logic [159:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[k*10 +: 10] = 10'(llr_val(sel, addr, k));
        return w;
    endfunction

    function automatic logic [95:0] exp_word(logic sel, int addr);
        logic [95:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[k*6 +: 6] = 6'(sat_ref(llr_val(sel, addr, k)));
        return w;
    endfunction

    // Combine-buffer model: registered read, muxed by the DUT's latched select.
    always @(posedge clk) comb_data <= build_word(buf_sel, int'(address));

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ind, input logic [15:0] ncb);
        int last;
        @(negedge clk);
        request   = 1'b1;
        indicator = ind;
        ncb_in    = ncb;
        last = (ncb[15:4] > 12'd2047) ? 2047 : int'(ncb[15:4]);
        for (int a = 0; a <= last; a++) exp_q.push_back(exp_word(ind, a));
        @(negedge clk);
        request = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (comp) done = 1'b1;
        end
        checkOutput("done_within_budget", {127'd0, done}, 128'd1);
    endtask

    // Transfer monitor: picks ready for the coming edge, then checks what will transfer.
    always @(negedge clk) begin
        ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                checkOutput("stall_valid", {127'd0, harq_bus.o_HARQ_Data_Valid}, 128'd1);
                checkOutput("stall_data", {32'd0, harq_bus.o_HARQ_Data}, {32'd0, stall_data});
            end
            stall_pending = harq_bus.o_HARQ_Data_Valid && !ready;
            stall_data    = harq_bus.o_HARQ_Data;
            if (harq_bus.o_HARQ_Data_Valid && ready) begin
                checkOutput("sb_has_entry", {127'd0, exp_q.size() > 0}, 128'd1);
                if (exp_q.size() > 0)
                    checkOutput("word", {32'd0, harq_bus.o_HARQ_Data}, {32'd0, exp_q.pop_front()});
                if (!ready_mode && words_in_txn > 0)
                    checkOutput("word_gap", 128'(cycle_count - last_xfer_cycle), 128'd1);
                last_xfer_cycle = cycle_count;
                words_in_txn++;
                words_total++;
            end
            if (comp) begin
                checkOutput("comp_sb_empty", 128'(exp_q.size()), 128'd0);
                checkOutput("comp_timing", 128'(cycle_count - last_xfer_cycle), 128'd1);
                comp_count++;
                words_in_txn = 0;
            end
        end
    end

    initial begin
        int saved_comp;
        int saved_words;
        check_count = 0; error_count = 0; cycle_count = 0; comp_count = 0;
        words_in_txn = 0; words_total = 0; last_xfer_cycle = 0;
        stall_pending = 1'b0; stall_data = '0;
        rst = 1'b1; request = 1'b0; indicator = 1'b0; ncb_in = '0;
        ready = 1'b1; ready_mode = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_addr", 128'(address), 128'd0);
        checkOutput("rst_sel", {127'd0, buf_sel}, 128'd0);
        checkOutput("rst_data", {32'd0, harq_bus.o_HARQ_Data}, 128'd0);
        checkOutput("rst_valid", {127'd0, harq_bus.o_HARQ_Data_Valid}, 128'd0);
        checkOutput("rst_comp", {127'd0, comp}, 128'd0);
        checkOutput("rst_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;

        // Five words from pong: address sequence and first-valid latency.
        applyStimulus(1'b1, 16'h0040);
        for (int k = 0; k < 5; k++) begin
            checkOutput("addr_seq", 128'(address), 128'(k));
            checkOutput("buf_sel", {127'd0, buf_sel}, 128'd1);
            checkOutput("busy", {127'd0, busy}, 128'd1);
            if (k == 1) checkOutput("valid_c1", {127'd0, harq_bus.o_HARQ_Data_Valid}, 128'd0);
            if (k == 2) checkOutput("valid_c2", {127'd0, harq_bus.o_HARQ_Data_Valid}, 128'd1);
            @(negedge clk);
        end
        waitDone(50);

        // Back-to-back requests: saturation pattern, then 17 words with random stalls.
        applyStimulus(1'b0, 16'h0010);
        waitDone(50);
        ready_mode = 1'b1;
        applyStimulus(1'b1, 16'h0100);
        waitDone(400);
        ready_mode = 1'b0;

        // Single word; a second request during READ must be ignored.
        repeat (2) @(negedge clk);
        saved_words = words_total;
        applyStimulus(1'b1, 16'h000F);
        request = 1'b1;
        @(negedge clk);
        request = 1'b0;
        waitDone(50);
        repeat (4) @(negedge clk);
        checkOutput("single_word_count", 128'(words_total - saved_words), 128'd1);
        checkOutput("single_idle", {127'd0, busy}, 128'd0);

        // Reset in the middle of a ten-word transfer, then replay.
        applyStimulus(1'b0, 16'h0090);
        for (int i = 0; i < 50 && words_in_txn < 3; i++) @(negedge clk);
        checkOutput("reached_word3", {127'd0, words_in_txn >= 3}, 128'd1);
        saved_comp = comp_count;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_addr", 128'(address), 128'd0);
        checkOutput("abort_sel", {127'd0, buf_sel}, 128'd0);
        checkOutput("abort_data", {32'd0, harq_bus.o_HARQ_Data}, 128'd0);
        checkOutput("abort_valid", {127'd0, harq_bus.o_HARQ_Data_Valid}, 128'd0);
        checkOutput("abort_comp", {127'd0, comp}, 128'd0);
        checkOutput("abort_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;
        exp_q.delete();
        words_in_txn = 0;
        repeat (3) @(negedge clk);
        checkOutput("no_comp_after_abort", 128'(comp_count), 128'(saved_comp));
        applyStimulus(1'b0, 16'h0090);
        checkOutput("replay_addr0", 128'(address), 128'd0);
        waitDone(60);

        // Ncb beyond the buffer: last address clamps to 2047.
        saved_words = words_total;
        applyStimulus(1'b1, 16'hFFFF);
        waitDone(2200);
        checkOutput("clamp_word_count", 128'(words_total - saved_words), 128'd2048);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", error_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
